// File: rtl/tone_period_meter.sv
// +----------------------------------------------------------------------+
// | tone_period_meter                                                    |
// | Times rising-edge period and high time of an asynchronous tone.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tone_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             silent
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [2:0]       sync_q,   sync_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hcnt_q,   hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic             valid_q,  valid_d;
    logic             silent_q, silent_d;
    logic             w_level;
    logic             w_rise;

    // sync_q[0] is the metastability stage; level and edge use the later two.
    assign w_level = sync_q[1];
    assign w_rise  = sync_q[1] & ~sync_q[2];

    always_comb begin
        sync_d   = {sync_q[1:0], sig_in};
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        silent_d = silent_q;

        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            silent_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ARM;
                    cnt_d    = '0;
                    hcnt_d   = '0;
                    silent_d = 1'b1;
                end
                ST_ARM: begin
                    if (w_rise) begin
                        cnt_d   = C_ONE;
                        hcnt_d  = C_ONE;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // A rise on the timeout cycle is still a legal measurement.
                    if (w_rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        silent_d = 1'b0;
                        cnt_d    = C_ONE;
                        hcnt_d   = C_ONE;
                    end else if (cnt_q == C_TIMEOUT) begin
                        silent_d = 1'b1;
                        period_d = '0;
                        high_d   = '0;
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        state_d  = ST_ARM;
                    end else begin
                        cnt_d  = cnt_q + C_ONE;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, w_level};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            silent_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            silent_q <= silent_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign silent    = silent_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_period_meter.sv
// +----------------------------------------------------------------------+
// | tb_tone_period_meter                                                 |
// | Directed and random tones checked against a timestamp-based model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tone_period_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 150;
    localparam int MAXC  = 16384;

    logic             clk;
    logic             reset;
    logic             sig_in;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             silent;

    tone_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .en        (en),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .silent    (silent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: sig_in value driven in each cycle; the tone level seen inside
    // the meter in cycle k is the input from cycle k-2.
    int xh [0:MAXC-1];
    int cyc    = 0;
    int mode   = 0;      // 0 disabled, 1 waiting for reference rise, 2 timing
    int last   = 0;      // cycle of the reference rise
    int ep     = 0;
    int eh     = 0;
    int ev     = 0;
    int es     = 1;
    int n_assert = 0;
    int n_fail   = 0;

    function automatic int lvl(input int k);
        return (k >= 2) ? xh[k-2] : 0;
    endfunction

    function automatic int lvl_prev(input int k);
        return (k >= 3) ? xh[k-3] : 0;
    endfunction

    task automatic model_edge(input logic x, input logic e, input logic r);
        int  sum;
        bit  rise;
        xh[cyc] = int'(x);
        ev = 0;
        if (r) begin
            mode = 0; ep = 0; eh = 0; es = 1;
            for (int i = 0; i < 3; i++)
                if (cyc - i >= 0) xh[cyc-i] = 0;
        end else if (!e) begin
            mode = 0; es = 1;
        end else begin
            rise = (lvl(cyc) == 1) && (lvl_prev(cyc) == 0);
            if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (rise) begin
                    last = cyc; mode = 2;
                end
            end else begin
                if (rise) begin
                    sum = 0;
                    for (int k = last; k < cyc; k++) sum += lvl(k);
                    ep = cyc - last; eh = sum; ev = 1; es = 0; last = cyc;
                end else if (cyc - last == TO) begin
                    es = 1; ep = 0; eh = 0; mode = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick(input logic x, input logic e, input logic r);
        if (cyc >= MAXC) begin
            $display("FAIL budget: observed cycle %0d required below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        sig_in = x;
        en     = e;
        reset  = r;
        @(posedge clk);
        model_edge(x, e, r);
        #1;
        n_assert++;
        assert (valid === ev[0]) else begin
            n_fail++;
            $error("FAIL valid: observed %0b expected %0d (cycle %0d)", valid, ev, cyc);
        end
        n_assert++;
        assert (silent === es[0]) else begin
            n_fail++;
            $error("FAIL silent: observed %0b expected %0d (cycle %0d)", silent, es, cyc);
        end
        n_assert++;
        assert (period === CNT_W'(ep)) else begin
            n_fail++;
            $error("FAIL period: observed %0d expected %0d (cycle %0d)", period, ep, cyc);
        end
        n_assert++;
        assert (high_time === CNT_W'(eh)) else begin
            n_fail++;
            $error("FAIL high_time: observed %0d expected %0d (cycle %0d)", high_time, eh, cyc);
        end
    endtask

    task automatic tone(input int p, input int h, input int n, input logic e);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++)
                tick(j < h, e, 1'b0);
    endtask

    task automatic hold(input int n, input logic x, input logic e);
        for (int i = 0; i < n; i++) tick(x, e, 1'b0);
    endtask

    initial begin
        int p, h, n;
        sig_in = 1'b0; en = 1'b0; reset = 1'b1;

        for (int i = 0; i < 3; i++) tick(1'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) tick(1'($urandom), 1'b0, 1'b0);

        tone(100, 50, 5, 1'b1);
        tone(100, 30, 3, 1'b1);
        tone(64, 32, 4, 1'b1);

        hold(200, 1'b0, 1'b1);
        tone(80, 20, 3, 1'b1);

        tone(TO, 10, 3, 1'b1);
        tone(TO + 1, 10, 3, 1'b1);

        hold(400, 1'b1, 1'b1);
        hold(5, 1'b0, 1'b1);

        tone(100, 50, 3, 1'b1);
        for (int j = 0; j < 40; j++) tick(j < 50, 1'b1, 1'b0);
        tone(100, 50, 2, 1'b0);
        tone(100, 50, 4, 1'b1);

        tone(60, 20, 3, 1'b1);
        for (int j = 0; j < 25; j++) tick(j < 20, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tone(60, 20, 4, 1'b1);

        for (int r = 0; r < 8; r++) begin
            p = $urandom_range(TO + 3, 4);
            h = $urandom_range(p - 1, 1);
            n = $urandom_range(4, 2);
            tone(p, h, n, 1'b1);
            if ($urandom_range(3, 0) == 0) hold($urandom_range(20, 1), 1'($urandom), 1'b0);
        end
        hold(TO + 10, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
